// File: rtl/addmacc_macro.sv
// addmacc_macro: DSP48-style pre-add, multiply and accumulate with a configurable pipeline latency.
// Register stages ahead of the accumulator: input regs (LATENCY=4), pre-add reg (>=3), multiply reg (>=2).
module addmacc_macro #(
  parameter int LATENCY          = 3,
  parameter int WIDTH_PREADD     = 25,
  parameter int WIDTH_MULTIPLIER = 18,
  parameter int WIDTH_PRODUCT    = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        CE,
  input  logic [WIDTH_PREADD-1:0]     PREADD1,
  input  logic [WIDTH_PREADD-1:0]     PREADD2,
  input  logic [WIDTH_MULTIPLIER-1:0] MULTIPLIER,
  input  logic                        CARRYIN,
  input  logic                        LOAD,
  input  logic [WIDTH_PRODUCT-1:0]    LOAD_DATA,
  output logic [WIDTH_PRODUCT-1:0]    PRODUCT
);
  localparam int WA = WIDTH_PREADD;
  localparam int WM = WIDTH_MULTIPLIER;
  localparam int WP = WIDTH_PRODUCT;
  localparam int PW = WA + 1;
  localparam int MW = PW + WM;
  localparam int CW = WP + 2;
  if (LATENCY < 1 || LATENCY > 4 || WA < 1 || WA > 25 || WM < 1 || WM > 18 || WP < 1 || WP > 48) begin : g_bad
    $error("addmacc_macro: parameter out of range");
  end
  logic signed [WA-1:0] a1, b1;
  logic signed [WM-1:0] mul1, mul2;
  logic signed [PW-1:0] pre_d, pre2;
  logic signed [MW-1:0] m_d, m3;
  logic [CW-1:0] ctl0, ctl1, ctl2, ctl3;
  logic [WP-1:0] acc_d;
  logic [WP-1:0] acc_q = '0;
  // Controls travel alongside their operands: {LOAD, CARRYIN, LOAD_DATA}
  assign ctl0 = {LOAD, CARRYIN, LOAD_DATA};
  if (LATENCY == 4) begin : g_in
    logic [WA-1:0] a_q = '0;
    logic [WA-1:0] b_q = '0;
    logic [WM-1:0] mul_q = '0;
    logic [CW-1:0] ctl_q = '0;
    always_ff @(posedge clk) begin
      if (rst) begin
        a_q   <= '0;
        b_q   <= '0;
        mul_q <= '0;
        ctl_q <= '0;
      end else if (CE) begin
        a_q   <= PREADD1;
        b_q   <= PREADD2;
        mul_q <= MULTIPLIER;
        ctl_q <= ctl0;
      end
    end
    assign a1   = a_q;
    assign b1   = b_q;
    assign mul1 = mul_q;
    assign ctl1 = ctl_q;
  end else begin : g_in_pass
    assign a1   = PREADD1;
    assign b1   = PREADD2;
    assign mul1 = MULTIPLIER;
    assign ctl1 = ctl0;
  end
  assign pre_d = PW'(a1) + PW'(b1);
  if (LATENCY >= 3) begin : g_pre
    logic [PW-1:0] pre_q = '0;
    logic [WM-1:0] mul_q = '0;
    logic [CW-1:0] ctl_q = '0;
    always_ff @(posedge clk) begin
      if (rst) begin
        pre_q <= '0;
        mul_q <= '0;
        ctl_q <= '0;
      end else if (CE) begin
        pre_q <= pre_d;
        mul_q <= mul1;
        ctl_q <= ctl1;
      end
    end
    assign pre2 = pre_q;
    assign mul2 = mul_q;
    assign ctl2 = ctl_q;
  end else begin : g_pre_pass
    assign pre2 = pre_d;
    assign mul2 = mul1;
    assign ctl2 = ctl1;
  end
  assign m_d = MW'(pre2) * MW'(mul2);
  if (LATENCY >= 2) begin : g_mul
    logic [MW-1:0] m_q = '0;
    logic [CW-1:0] ctl_q = '0;
    always_ff @(posedge clk) begin
      if (rst) begin
        m_q   <= '0;
        ctl_q <= '0;
      end else if (CE) begin
        m_q   <= m_d;
        ctl_q <= ctl2;
      end
    end
    assign m3   = m_q;
    assign ctl3 = ctl_q;
  end else begin : g_mul_pass
    assign m3   = m_d;
    assign ctl3 = ctl2;
  end
  // Product is sign-extended or truncated to the accumulator width; sum wraps modulo 2^WP
  assign acc_d = WP'(m3) + (ctl3[CW-1] ? ctl3[WP-1:0] : acc_q) + WP'(ctl3[WP]);
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else if (CE) acc_q <= acc_d;
  end
  assign PRODUCT = acc_q;
endmodule

// File: tb/tb_addmacc_macro.sv
// tb_addmacc_macro: directed checks of addmacc_macro at LATENCY 1..4 and an 8-bit product variant.
module tb_addmacc_macro;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic ci = 1'b0;
  logic ld = 1'b0;
  logic [24:0] pa = '0;
  logic [24:0] pb = '0;
  logic [17:0] mu = '0;
  logic [47:0] ldd = '0;
  logic [47:0] p [1:4];
  logic [7:0] p8;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  for (genvar l = 1; l <= 4; l++) begin : g_dut
    addmacc_macro #(.LATENCY(l)) dut (
      .clk(clk), .rst(rst), .CE(ce), .PREADD1(pa), .PREADD2(pb), .MULTIPLIER(mu),
      .CARRYIN(ci), .LOAD(ld), .LOAD_DATA(ldd), .PRODUCT(p[l])
    );
  end
  addmacc_macro #(.LATENCY(1), .WIDTH_PRODUCT(8)) dut8 (
    .clk(clk), .rst(rst), .CE(ce), .PREADD1(pa), .PREADD2(pb), .MULTIPLIER(mu),
    .CARRYIN(ci), .LOAD(ld), .LOAD_DATA(ldd[7:0]), .PRODUCT(p8)
  );
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ops(input logic [24:0] a, input logic [24:0] b, input logic [17:0] m,
                     input logic l, input logic [47:0] d, input logic c);
    pa = a;
    pb = b;
    mu = m;
    ld = l;
    ldd = d;
    ci = c;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  logic        st_ce  [1:13] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  logic [24:0] st_p1  [1:13] = '{1, 2, 3, 4, 5, 99, 99, 99, 6, 0, 0, 0, 0};
  logic [47:0] st_exp [1:13] = '{0, 0, 0, 1, 3, 3, 3, 3, 6, 10, 15, 21, 21};
  logic [47:0] mac_exp [1:7] = '{0, 0, 0, 16, 32, 48, 64};
  initial begin
    step();
    rst = 1'b0;
    for (int l = 1; l <= 4; l++) chk($sformatf("reset_p%0d", l), p[l], 48'd0);
    chk("reset_p8", 48'(p8), 48'd0);
    // plain MAC at LATENCY=4, then reset while CE=0
    ce = 1'b1;
    ops(25'd5, 25'd3, 18'd2, 1'b1, 48'd0, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      step();
      ld = 1'b0;
      chk($sformatf("mac_e%0d", e), p[4], mac_exp[e]);
    end
    ce = 1'b0;
    do_reset();
    chk("rst_ce0", p[4], 48'd0);
    ce = 1'b1;
    ops(25'd1, 25'd0, 18'd1, 1'b0, 48'd0, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("post_rst_e%0d", e), p[4], (e < 4) ? 48'd0 : 48'(e - 3));
    end
    // signed operands: (2-7)*-3 + 100 + 1 = 116
    do_reset();
    ops(25'd2, 25'(-7), 18'(-3), 1'b1, 48'd100, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("signed_p%0d_e%0d", e, e), p[e], 48'd116);
      if (e == 2) chk("signed_p3_e2", p[3], 48'd0);
    end
    ops(25'h1000000, 25'h1000000, 18'h20000, 1'b1, 48'd0, 1'b0);
    for (int e = 1; e <= 4; e++) step();
    for (int l = 1; l <= 4; l++) chk($sformatf("extreme_p%0d", l), p[l], 48'h0400_0000_0000);
    // wrap-around at 8 bits versus 48 bits
    do_reset();
    ops(25'd1, 25'd0, 18'd1, 1'b1, 48'd127, 1'b0);
    step();
    chk("wrap_p8", 48'(p8), 48'h80);
    chk("nowrap_p1", p[1], 48'd128);
    // CE stall mid-stream at LATENCY=4
    do_reset();
    ops(25'd0, 25'd0, 18'd1, 1'b0, 48'd0, 1'b0);
    for (int e = 1; e <= 13; e++) begin
      ce = st_ce[e];
      pa = st_p1[e];
      step();
      chk($sformatf("stall_e%0d", e), p[4], st_exp[e]);
    end
    // latency sweep impulse
    ce = 1'b1;
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      ops((e == 1) ? 25'd1 : 25'd0, 25'd0, (e == 1) ? 18'd1 : 18'd0, 1'b1, 48'd0, 1'b0);
      step();
      for (int l = 1; l <= 4; l++) chk($sformatf("impulse_p%0d_e%0d", l, e), p[l], (e == l) ? 48'd1 : 48'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
